rv_iopmp_tl_arbiter: RTL and testbench



---
 rtl/rv_iopmp_pkg.sv | 23 ++
 rtl/rv_iopmp_rr_select.sv | 36 +++
 rtl/rv_iopmp_tl_arbiter.sv | 144 ++++++++++++++
 tb/tb_rv_iopmp_tl_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP transaction-level front end.
// Contents:
//   access_t        - access type carried with every check request
//   tl_arb_state_e  - state encoding of the transaction-level arbiter
//   TL_ARB_CNT_W    - width of the arbiter's in-flight timeout counter
package rv_iopmp_pkg;

   typedef enum logic [1:0] {
      ACC_NONE  = 2'd0,
      ACC_READ  = 2'd1,
      ACC_WRITE = 2'd2,
      ACC_EXEC  = 2'd3
   } access_t;

   typedef enum logic [1:0] {
      TL_ARB_IDLE  = 2'd0,
      TL_ARB_ISSUE = 2'd1,
      TL_ARB_WAIT  = 2'd2
   } tl_arb_state_e;

   localparam int TL_ARB_CNT_W = 16;

endpackage

// File: rtl/rv_iopmp_rr_select.sv
// Wrap-around first-set search used for round-robin arbitration.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - index where the search starts (highest priority this round)
//   index  - first set request at or after rr_ptr, wrapping past NUM_REQ-1
//   found  - at least one request bit is set; index is 0 when clear
module rv_iopmp_rr_select #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   index,
   output logic               found
);

   int cand;

   // Walk the requesters starting at rr_ptr; the first hit locks the result.
   always_comb begin
      index = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!found && req[IDX_W'(cand)]) begin
            found = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rv_iopmp_tl_arbiter.sv
// Round-robin arbiter letting several transaction-level requesters share one
// IOPMP matching-logic instance, with a forced deny when a check hangs.
// Ports:
//   clk_i, rst_ni           - clock and asynchronous active-low reset
//   req_*_i                 - per-requester check request and its fields
//   req_ready_o             - all ones while idle (a new request may be taken)
//   req_valid_o/allow_o     - one-cycle result pulse to the granted requester
//   ml_*_o                  - latched request presented to the matching logic
//   ml_ready_i/valid_i/allow_i - matching-logic handshake and result
//   grant_o                 - owning requester index (steers error capture)
//   busy_o                  - a check is in flight
//   timeout_o               - one-cycle pulse when a check is force-denied
module rv_iopmp_tl_arbiter
   import rv_iopmp_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int SID_WIDTH      = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                           clk_i,
   input  logic                                           rst_ni,
   input  logic [NUM_REQ-1:0]                             req_transaction_en_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]             req_addr_i,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]             req_total_length_i,
   input  logic [NUM_REQ-1:0][$clog2(DATA_WIDTH/8):0]     req_num_bytes_i,
   input  logic [NUM_REQ-1:0][SID_WIDTH-1:0]              req_sid_i,
   input  access_t [NUM_REQ-1:0]                          req_access_type_i,
   output logic [NUM_REQ-1:0]                             req_ready_o,
   output logic [NUM_REQ-1:0]                             req_valid_o,
   output logic [NUM_REQ-1:0]                             req_allow_o,
   output logic                                           ml_transaction_en_o,
   output logic [ADDR_WIDTH-1:0]                          ml_addr_o,
   output logic [ADDR_WIDTH-1:0]                          ml_total_length_o,
   output logic [$clog2(DATA_WIDTH/8):0]                  ml_num_bytes_o,
   output logic [SID_WIDTH-1:0]                           ml_sid_o,
   output access_t                                        ml_access_type_o,
   input  logic                                           ml_ready_i,
   input  logic                                           ml_valid_i,
   input  logic                                           ml_allow_i,
   output logic [$clog2(NUM_REQ)-1:0]                     grant_o,
   output logic                                           busy_o,
   output logic                                           timeout_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [TL_ARB_CNT_W-1:0] TIMEOUT_LAST = TL_ARB_CNT_W'(TIMEOUT_CYCLES - 1);

   tl_arb_state_e           state;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        rr_next;
   logic [IDX_W-1:0]        sel_idx;
   logic                    sel_found;
   logic [TL_ARB_CNT_W-1:0] cnt;
   logic                    expire;
   logic                    result_hit;

   rv_iopmp_rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_select (
      .req    (req_transaction_en_i),
      .rr_ptr (rr_ptr),
      .index  (sel_idx),
      .found  (sel_found)
   );

   // The counter runs through both ISSUE and WAIT, so a matching logic that
   // never accepts the request is bounded just like one that never answers.
   assign expire     = (state != TL_ARB_IDLE) && (cnt == TIMEOUT_LAST);
   assign result_hit = (state == TL_ARB_WAIT) && ml_valid_i;
   assign rr_next    = (int'(grant_o) == NUM_REQ - 1) ? '0 : grant_o + 1'b1;

   assign busy_o              = (state != TL_ARB_IDLE);
   assign ml_transaction_en_o = (state == TL_ARB_ISSUE);
   assign req_ready_o         = {NUM_REQ{state == TL_ARB_IDLE}};

   // The result pulse is decoded from the registered state so it lands in the
   // same cycle ml_valid_i arrives; a real result beats a coincident timeout.
   always_comb begin
      req_valid_o = '0;
      req_allow_o = '0;
      timeout_o   = 1'b0;
      if (result_hit) begin
         req_valid_o[grant_o] = 1'b1;
         req_allow_o[grant_o] = ml_allow_i;
      end else if (expire) begin
         req_valid_o[grant_o] = 1'b1;
         timeout_o            = 1'b1;
      end
   end

   // IDLE latches the winner's fields once, so they stay stable for the
   // whole check even if the requester drops or changes its inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state             <= TL_ARB_IDLE;
         rr_ptr            <= '0;
         grant_o           <= '0;
         cnt               <= '0;
         ml_addr_o         <= '0;
         ml_total_length_o <= '0;
         ml_num_bytes_o    <= '0;
         ml_sid_o          <= '0;
         ml_access_type_o  <= ACC_NONE;
      end else begin
         case (state)
            TL_ARB_IDLE: begin
               if (sel_found) begin
                  state             <= TL_ARB_ISSUE;
                  grant_o           <= sel_idx;
                  cnt               <= '0;
                  ml_addr_o         <= req_addr_i[sel_idx];
                  ml_total_length_o <= req_total_length_i[sel_idx];
                  ml_num_bytes_o    <= req_num_bytes_i[sel_idx];
                  ml_sid_o          <= req_sid_i[sel_idx];
                  ml_access_type_o  <= req_access_type_i[sel_idx];
               end
            end
            TL_ARB_ISSUE: begin
               cnt <= cnt + 1'b1;
               if (expire) begin
                  state  <= TL_ARB_IDLE;
                  rr_ptr <= rr_next;
               end else if (ml_ready_i) begin
                  state <= TL_ARB_WAIT;
               end
            end
            TL_ARB_WAIT: begin
               cnt <= cnt + 1'b1;
               if (result_hit || expire) begin
                  state  <= TL_ARB_IDLE;
                  rr_ptr <= rr_next;
               end
            end
            default: begin
               state <= TL_ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
// Directed bench for rv_iopmp_tl_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Inputs change just after the rising edge; outputs are compared on the
// falling edge of the same cycle.
module tb_rv_iopmp_tl_arbiter;
   import rv_iopmp_pkg::*;

   localparam logic [63:0] A0 = 64'h0000_0000_8000_1000;
   localparam logic [63:0] A1 = 64'h0000_0000_4000_2000;

   logic                 clk_i;
   logic                 rst_ni;
   logic [1:0]           req_transaction_en_i;
   logic [1:0][63:0]     req_addr_i;
   logic [1:0][63:0]     req_total_length_i;
   logic [1:0][3:0]      req_num_bytes_i;
   logic [1:0][0:0]      req_sid_i;
   access_t [1:0]        req_access_type_i;
   logic [1:0]           req_ready_o;
   logic [1:0]           req_valid_o;
   logic [1:0]           req_allow_o;
   logic                 ml_transaction_en_o;
   logic [63:0]          ml_addr_o;
   logic [63:0]          ml_total_length_o;
   logic [3:0]           ml_num_bytes_o;
   logic [0:0]           ml_sid_o;
   access_t              ml_access_type_o;
   logic                 ml_ready_i;
   logic                 ml_valid_i;
   logic                 ml_allow_i;
   logic [0:0]           grant_o;
   logic                 busy_o;
   logic                 timeout_o;

   int checks = 0;
   int errors = 0;

   rv_iopmp_tl_arbiter #(
      .NUM_REQ        (2),
      .ADDR_WIDTH     (64),
      .DATA_WIDTH     (64),
      .SID_WIDTH      (1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .req_transaction_en_i (req_transaction_en_i),
      .req_addr_i           (req_addr_i),
      .req_total_length_i   (req_total_length_i),
      .req_num_bytes_i      (req_num_bytes_i),
      .req_sid_i            (req_sid_i),
      .req_access_type_i    (req_access_type_i),
      .req_ready_o          (req_ready_o),
      .req_valid_o          (req_valid_o),
      .req_allow_o          (req_allow_o),
      .ml_transaction_en_o  (ml_transaction_en_o),
      .ml_addr_o            (ml_addr_o),
      .ml_total_length_o    (ml_total_length_o),
      .ml_num_bytes_o       (ml_num_bytes_o),
      .ml_sid_o             (ml_sid_o),
      .ml_access_type_o     (ml_access_type_o),
      .ml_ready_i           (ml_ready_i),
      .ml_valid_i           (ml_valid_i),
      .ml_allow_i           (ml_allow_i),
      .grant_o              (grant_o),
      .busy_o               (busy_o),
      .timeout_o            (timeout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // One record per clock cycle: inputs applied, outputs expected.
   typedef struct {
      logic [1:0]  en;
      logic        mlRdy;
      logic        mlVld;
      logic        mlAllow;
      logic        expBusy;
      logic        expMlEn;
      logic [1:0]  expRdy;
      logic [1:0]  expVal;
      logic [1:0]  expAllow;
      logic        expGrant;
      logic        expTo;
      logic [63:0] expAddr;
   } vec_t;

   vec_t vecs[17];

   task automatic applyStimulus(input logic [1:0] en, input logic rdy,
                                input logic vld, input logic allow);
      req_transaction_en_i = en;
      ml_ready_i           = rdy;
      ml_valid_i           = vld;
      ml_allow_i           = allow;
      @(negedge clk_i);
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkResult(input string tag, input logic [1:0] val,
                              input logic [1:0] allow, input logic to);
      checkOutput({tag, " req_valid"}, 64'(req_valid_o), 64'(val));
      checkOutput({tag, " req_allow"}, 64'(req_allow_o), 64'(allow));
      checkOutput({tag, " timeout"},   64'(timeout_o),   64'(to));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Requester 0 and 1 carry distinct fields so latching the wrong one shows.
      req_addr_i[0]         = A0;
      req_addr_i[1]         = A1;
      req_total_length_i[0] = 64'h40;
      req_total_length_i[1] = 64'h100;
      req_num_bytes_i[0]    = 4'd8;
      req_num_bytes_i[1]    = 4'd4;
      req_sid_i[0]          = 1'b1;
      req_sid_i[1]          = 1'b0;
      req_access_type_i[0]  = ACC_WRITE;
      req_access_type_i[1]  = ACC_READ;

      //           en     rdy   vld   alw   busy  mlEn  rdy    val    allow  gnt   to    addr
      vecs[0]  = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 64'h0};
      vecs[2]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, A0};
      vecs[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[5]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, A1};
      vecs[6]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, A1};
      vecs[7]  = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, A1};
      vecs[8]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, A1};
      vecs[9]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, A1};
      vecs[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, A1};
      vecs[11] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[13] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, A0};
      vecs[14] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[15] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0};
      vecs[16] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, A0};

      // Reset state, checked while reset is still asserted.
      rst_ni = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("rst busy",   64'(busy_o),              64'h0);
      checkOutput("rst ml_en",  64'(ml_transaction_en_o), 64'h0);
      checkOutput("rst grant",  64'(grant_o),             64'h0);
      checkOutput("rst addr",   ml_addr_o,                64'h0);
      checkResult("rst", 2'b00, 2'b00, 1'b0);
      nextCycle();
      rst_ni = 1'b1;

      // Table-driven cycles: round-robin, dropped enable, ISSUE hold, wrap search.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].mlRdy, vecs[i].mlVld, vecs[i].mlAllow);
         checkOutput($sformatf("vec%0d busy", i),  64'(busy_o),              64'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d ml_en", i), 64'(ml_transaction_en_o), 64'(vecs[i].expMlEn));
         checkOutput($sformatf("vec%0d ready", i), 64'(req_ready_o),         64'(vecs[i].expRdy));
         checkOutput($sformatf("vec%0d grant", i), 64'(grant_o),             64'(vecs[i].expGrant));
         checkOutput($sformatf("vec%0d addr", i),  ml_addr_o,                vecs[i].expAddr);
         checkResult($sformatf("vec%0d", i), vecs[i].expVal, vecs[i].expAllow, vecs[i].expTo);
         nextCycle();
      end

      // ml_ready_i held low for 5 ISSUE cycles; fields stay latched.
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
      nextCycle();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d ml_en", k), 64'(ml_transaction_en_o), 64'h1);
         checkOutput($sformatf("hold%0d addr", k),  ml_addr_o,                A0);
         checkOutput($sformatf("hold%0d ready", k), 64'(req_ready_o),         64'h0);
         nextCycle();
      end
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("hold rise ml_en", 64'(ml_transaction_en_o), 64'h1);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b1);
      checkOutput("hold wait ml_en", 64'(ml_transaction_en_o), 64'h0);
      checkOutput("hold wait busy",  64'(busy_o),              64'h1);
      checkOutput("hold len",    ml_total_length_o,        64'h40);
      checkOutput("hold nbytes", 64'(ml_num_bytes_o),      64'h8);
      checkOutput("hold sid",    64'(ml_sid_o),            64'h1);
      checkOutput("hold access", 64'(ml_access_type_o),    64'(ACC_WRITE));
      checkResult("hold wait", 2'b01, 2'b01, 1'b0);
      nextCycle();

      // Timeout: requester 1, matching logic accepts but never answers.
      applyStimulus(2'b10, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("to issue grant", 64'(grant_o), 64'h1);
      nextCycle();
      for (int k = 1; k < 7; k++) begin
         applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
         checkResult($sformatf("to wait%0d", k), 2'b00, 2'b00, 1'b0);
         nextCycle();
      end
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
      checkResult("to expire", 2'b10, 2'b00, 1'b1);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
      checkOutput("to after busy", 64'(busy_o), 64'h0);
      checkResult("to after", 2'b00, 2'b00, 1'b0);
      nextCycle();

      // Real result on the expiry cycle wins over the timeout.
      applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      nextCycle();
      for (int k = 1; k < 7; k++) begin
         applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
         nextCycle();
      end
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b1);
      checkResult("race", 2'b01, 2'b01, 1'b0);
      nextCycle();

      // Reset in WAIT abandons the check; pointer returns to requester 0.
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
      checkOutput("prerst grant", 64'(grant_o), 64'h1);
      checkOutput("prerst busy",  64'(busy_o),  64'h1);
      #1;
      rst_ni = 1'b0;
      #1;
      ml_valid_i = 1'b1;
      ml_allow_i = 1'b1;
      #1;
      checkResult("midrst", 2'b00, 2'b00, 1'b0);
      checkOutput("midrst busy",  64'(busy_o),      64'h0);
      checkOutput("midrst ready", 64'(req_ready_o), 64'h3);
      nextCycle();
      rst_ni = 1'b1;
      applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
      checkOutput("postrst busy",  64'(busy_o),      64'h0);
      checkOutput("postrst ready", 64'(req_ready_o), 64'h3);
      checkResult("postrst", 2'b00, 2'b00, 1'b0);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst grant", 64'(grant_o), 64'h0);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b1);
      checkResult("postrst done", 2'b01, 2'b01, 1'b0);
      nextCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
